// File: rtl/rv_fetch_stage.sv
// rv_fetch_stage: RISC-V instruction-fetch stage.
// Owns the PC, addresses the combinational instruction ROM, and registers
// each fetched word into the IF/ID register. Handles decode back-pressure,
// redirects, misaligned-redirect and out-of-range fetch faults (HALT).
// Optional feature macro: FETCH_PERF_CNT_EN (fetch/stall performance counters).
module rv_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ROM_SIZE = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  // 33-bit bound so ROM_SIZE*4 == 2^32 does not overflow the compare.
  localparam logic [32:0] ROM_BYTES = 33'(ROM_SIZE) * 33'd4;

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        adv, out_of_range, issue;

  assign adv          = !valid_q || id_ready;
  assign out_of_range = {1'b0, pc_q} >= ROM_BYTES;

  // Next-state: redirect beats stall/advance; BOOT ignores redirects.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    issue   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, HALT: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_d    = redirect_pc;
            state_d = RUN;
          end else begin
            state_d = HALT;
          end
        end else if (state_q == RUN && adv) begin
          if (out_of_range) begin
            valid_d = 1'b0;
            state_d = HALT;
          end else begin
            issue   = 1'b1;
            valid_d = 1'b1;
            instr_d = rom_data;
            ipc_d   = pc_q;
            ipc4_d  = pc_q + 32'd4;
            pc_d    = pc_q + 32'd4;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State, PC and IF/ID register; reset discards IF/ID contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP;
      ipc_q   <= 32'h0;
      ipc4_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
    end
  end

  assign rom_addr    = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ipc_q;
  assign if_pc_plus4 = ipc4_q;
  assign fetch_fault = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count issues and back-pressured RUN cycles; both wrap at 2^32.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (issue) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (state_q == RUN && valid_q && !id_ready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  logic unused_issue;
  assign unused_issue   = issue;
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule
